// File: rtl/pipelined_addsub_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub_unit
// Purpose  : Two-stage pipelined integer ADD/SUB/ADC/SBB unit with a
//            valid/ready handshake, {C,Z,N,V} flags and a pass-through tag.
//            Stage 1 builds the low-half carry-lookahead sum. Stage 2
//            finishes the upper half from the stored carry and forms flags.
// Options  : define ADDSUB_SAT_EN to enable signed saturation on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_addsub_unit #(
    parameter int WIDTH    = 8,
    parameter int RESULT_W = 12,
    parameter int TAG_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic                in_cin,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RESULT_W-1:0] out_result,
    output logic [3:0]          out_flags,
    output logic [TAG_W-1:0]    out_tag
);

    // Both halves are the same width because WIDTH is even.
    localparam int LO_W = WIDTH / 2;

    // Opcode encoding. Bit 0 selects subtraction and bit 1 selects the
    // external carry-in, so the decode below uses the bits directly.
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    // Carry-lookahead adder over LO_W bits. The bits are split into 4-bit
    // groups. Each carry inside a group is expanded from the group's
    // carry-in. Group carries chain from one group to the next.
    // The function returns {carry_out, sum}.
    function automatic logic [LO_W:0] cla_add(
        input logic [LO_W-1:0] p,
        input logic [LO_W-1:0] g,
        input logic            cin
    );
        logic [LO_W:0]   c;
        logic [LO_W-1:0] s;
        logic            pp;
        logic            cj;
        int              base;
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int j = 0; j < LO_W; j++) begin
            base = (j / 4) * 4;
            cj   = 1'b0;
            pp   = 1'b1;
            for (int k = j; k >= base; k--) begin
                cj = cj | (g[k] & pp);
                pp = pp & p[k];
            end
            c[j+1] = cj | (pp & c[base]);
        end
        for (int j = 0; j < LO_W; j++) begin
            s[j] = p[j] ^ c[j];
        end
        return {c[LO_W], s};
    endfunction

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic               s1_valid;
    logic [LO_W-1:0]    s1_lo_sum;
    logic               s1_lo_cout;
    logic [LO_W-1:0]    s1_p_hi;
    logic [LO_W-1:0]    s1_g_hi;
    logic               s1_a_msb;
    logic [TAG_W-1:0]   s1_tag;

    logic               s2_valid;
    logic [WIDTH-1:0]   s2_sum;
    logic [3:0]         s2_flags;
    logic [TAG_W-1:0]   s2_tag;

    logic               s2_adv;
    logic               accept;

    // ------------------------------------------------------------------
    // Stage 1 combinational: operand conditioning and low-half sum
    // ------------------------------------------------------------------
    logic               sub;
    logic               c0;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH-1:0]   g_all;
    logic [WIDTH-1:0]   p_all;
    logic [LO_W:0]      lo_add;

    // Invert B for subtracting ops, pick the carry-in, and add the low half.
    always_comb begin
        sub    = in_op[0];
        c0     = in_op[1] ? in_cin : in_op[0];
        b_eff  = in_b ^ {WIDTH{sub}};
        g_all  = in_a & b_eff;
        p_all  = in_a ^ b_eff;
        lo_add = cla_add(p_all[LO_W-1:0], g_all[LO_W-1:0], c0);
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: upper-half sum, overflow and flags
    // ------------------------------------------------------------------
    logic [LO_W:0]      hi_add;
    logic [WIDTH-1:0]   raw_sum;
    logic [WIDTH-1:0]   fin_sum;
    logic               carry;
    logic               b_msb;
    logic               ovf;
    logic [3:0]         flags_nxt;

    // Complete the sum from the stored half-carry, then derive the flags.
    // B' msb is recovered as P^A, so only the A msb needs to be stored.
    always_comb begin
        hi_add  = cla_add(s1_p_hi, s1_g_hi, s1_lo_cout);
        raw_sum = {hi_add[LO_W-1:0], s1_lo_sum};
        carry   = hi_add[LO_W];
        b_msb   = s1_p_hi[LO_W-1] ^ s1_a_msb;
        ovf     = (s1_a_msb == b_msb) && (raw_sum[WIDTH-1] != s1_a_msb);
`ifdef ADDSUB_SAT_EN
        // Clamp toward the sign of A. Both operands share that sign whenever
        // overflow occurs.
        if (ovf) begin
            fin_sum = s1_a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            fin_sum = raw_sum;
        end
`else
        fin_sum = raw_sum;
`endif
        flags_nxt = {carry, (fin_sum == '0), fin_sum[WIDTH-1], ovf};
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // Stage 2 can advance when it is empty or its result is being taken.
    // Stage 1 can accept when it is empty or it can move into stage 2.
    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        in_ready = !s1_valid || s2_adv;
        accept   = in_valid && in_ready;
    end

    // Stage 1 register: capture the low-half result and upper-half P/G on accept.
    // The op needs no storage because it is fully folded into P/G and the carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_lo_sum  <= '0;
            s1_lo_cout <= 1'b0;
            s1_p_hi    <= '0;
            s1_g_hi    <= '0;
            s1_a_msb   <= 1'b0;
            s1_tag     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_lo_sum  <= lo_add[LO_W-1:0];
                s1_lo_cout <= lo_add[LO_W];
                s1_p_hi    <= p_all[WIDTH-1:LO_W];
                s1_g_hi    <= g_all[WIDTH-1:LO_W];
                s1_a_msb   <= in_a[WIDTH-1];
                s1_tag     <= in_tag;
            end
        end
    end

    // Stage 2 register: take the finished result whenever stage 2 may advance.
    // Data is held while out_valid is stalled by out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_flags <= '0;
            s2_tag   <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum   <= fin_sum;
                s2_flags <= flags_nxt;
                s2_tag   <= s1_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = s2_valid;
    assign out_flags = s2_flags;
    assign out_tag   = s2_tag;

    generate
        if (RESULT_W > WIDTH) begin : g_zero_ext
            assign out_result = {{(RESULT_W-WIDTH){1'b0}}, s2_sum};
        end else begin : g_no_ext
            assign out_result = s2_sum;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_addsub_unit
// Purpose  : Self-checking bench for pipelined_addsub_unit. It runs directed
//            cases, back-pressure and reset scenarios, and randomized traffic
//            checked by a scoreboard against a signed/unsigned arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_addsub_unit;

    localparam int WIDTH    = 8;
    localparam int RESULT_W = 12;
    localparam int TAG_W    = 4;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_op;
    logic [WIDTH-1:0]    in_a;
    logic [WIDTH-1:0]    in_b;
    logic                in_cin;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [RESULT_W-1:0] out_result;
    logic [3:0]          out_flags;
    logic [TAG_W-1:0]    out_tag;

    pipelined_addsub_unit #(
        .WIDTH    (WIDTH),
        .RESULT_W (RESULT_W),
        .TAG_W    (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_tag    (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    typedef struct packed {
        logic [RESULT_W-1:0] res;
        logic [3:0]          flags;
        logic [TAG_W-1:0]    tag;
    } exp_t;

    // Reference: evaluate the operation as true unsigned and signed integers.
    function automatic exp_t model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic cin,
                                   input logic [TAG_W-1:0] tag);
        exp_t e;
        int ua, ub, sa, sb, u, s, sum, c, z, n, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            2'd0:    begin u = ua + ub;                 s = sa + sb;                 end
            2'd1:    begin u = ua - ub;                 s = sa - sb;                 end
            2'd2:    begin u = ua + ub + int'(cin);     s = sa + sb + int'(cin);     end
            default: begin u = ua - ub - int'(!cin);    s = sa - sb - int'(!cin);    end
        endcase
        if (op[0]) c = (u >= 0) ? 1 : 0;
        else       c = (u >= (1 << WIDTH)) ? 1 : 0;
        v   = (s > (1 << (WIDTH-1)) - 1 || s < -(1 << (WIDTH-1))) ? 1 : 0;
        sum = u & ((1 << WIDTH) - 1);
`ifdef ADDSUB_SAT_EN
        if (v == 1) sum = (s > 0) ? (1 << (WIDTH-1)) - 1 : (1 << (WIDTH-1));
`endif
        z = (sum == 0) ? 1 : 0;
        n = (sum >> (WIDTH-1)) & 1;
        e.res   = RESULT_W'(sum);
        e.flags = {c[0], z[0], n[0], v[0]};
        e.tag   = tag;
        return e;
    endfunction

    // Scoreboard: sampled at the falling edge, away from the active edge.
    // Outputs are checked against the oldest outstanding op every cycle they
    // are valid, so stalled outputs are also checked for stability.
    exp_t q[$];
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    check("sb_result", 32'(out_result), 32'(q[0].res));
                    check("sb_flags",  32'(out_flags),  32'(q[0].flags));
                    check("sb_tag",    32'(out_tag),    32'(q[0].tag));
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_op, in_a, in_b, in_cin, in_tag));
        end
    end

    task automatic drive(input logic [1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_tag   = tag;
    endtask

    // Single op into an empty pipe with out_ready=1. The result must appear
    // after the second rising edge that follows presentation.
    task automatic do_op(input string name, input logic [1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin, input logic [TAG_W-1:0] tag,
                         input logic [RESULT_W-1:0] exp_res, input logic [3:0] exp_flags);
        @(posedge clk); #1;
        drive(op, a, b, cin, tag);
        @(negedge clk);
        check({name, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({name, "_lat2"}, 32'(out_valid), 32'd1);
        check({name, "_res"},  32'(out_result), 32'(exp_res));
        check({name, "_flg"},  32'(out_flags),  32'(exp_flags));
        check({name, "_tag"},  32'(out_tag),    32'(tag));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ovalid", 32'(out_valid),  32'd0);
        check("rst_result", 32'(out_result), 32'd0);
        check("rst_flags",  32'(out_flags),  32'd0);
        check("rst_tag",    32'(out_tag),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_iready", 32'(in_ready), 32'd1);

        // Directed arithmetic cases; flags are {C,Z,N,V}
        do_op("sub_pos", 2'b01, 8'h05, 8'h03, 1'b0, 4'd1, 12'h002, 4'b1000);
        do_op("sub_neg", 2'b01, 8'h03, 8'h05, 1'b0, 4'd2, 12'h0FE, 4'b0010);
        do_op("add_wrap", 2'b00, 8'hFF, 8'h01, 1'b0, 4'd3, 12'h000, 4'b1100);
`ifdef ADDSUB_SAT_EN
        do_op("add_ovf", 2'b00, 8'h7F, 8'h01, 1'b0, 4'd4, 12'h07F, 4'b0001);
`else
        do_op("add_ovf", 2'b00, 8'h7F, 8'h01, 1'b0, 4'd4, 12'h080, 4'b0011);
`endif
        do_op("adc", 2'b10, 8'h10, 8'h20, 1'b1, 4'd5, 12'h031, 4'b0000);
        do_op("sbb", 2'b11, 8'h10, 8'h01, 1'b0, 4'd6, 12'h00E, 4'b1000);

        // Back-pressure: the consumer stalls while four ops are offered
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(2'b00, 8'h00, 8'h10, 1'b0, 4'd0);
        @(negedge clk);
        check("bp_rdy0", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        drive(2'b00, 8'h01, 8'h10, 1'b0, 4'd1);
        @(negedge clk);
        check("bp_rdy1", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        drive(2'b00, 8'h02, 8'h10, 1'b0, 4'd2);
        @(negedge clk);
        check("bp_full", 32'(in_ready), 32'd0);
        check("bp_hold", 32'(out_tag),  32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_o0v", 32'(out_valid), 32'd1);
        check("bp_o0",  32'(out_tag),   32'd0);
        check("bp_rdy2", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        drive(2'b00, 8'h03, 8'h10, 1'b0, 4'd3);
        @(negedge clk);
        check("bp_o1v", 32'(out_valid), 32'd1);
        check("bp_o1",  32'(out_tag),   32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_o2v", 32'(out_valid), 32'd1);
        check("bp_o2",  32'(out_tag),   32'd2);
        @(negedge clk);
        check("bp_o3v", 32'(out_valid), 32'd1);
        check("bp_o3",  32'(out_tag),   32'd3);
        @(negedge clk);
        check("bp_empty", 32'(out_valid), 32'd0);

        // Reset mid-stream with two ops in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(2'b00, 8'h11, 8'h22, 1'b0, 4'd9);
        @(posedge clk); #1;
        drive(2'b01, 8'h33, 8'h04, 1'b0, 4'd10);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_ovalid", 32'(out_valid),  32'd0);
        check("mrst_result", 32'(out_result), 32'd0);
        check("mrst_flags",  32'(out_flags),  32'd0);
        check("mrst_tag",    32'(out_tag),    32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("mrst_iready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mrst_stale", 32'(out_valid), 32'd0);
        end

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            in_op     = 2'($urandom_range(0, 3));
            in_a      = WIDTH'($urandom);
            in_b      = WIDTH'($urandom);
            in_cin    = 1'($urandom_range(0, 1));
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("drain_empty", 32'(q.size()), 32'd0);
        check("drain_ovalid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
